// File: rtl/block_pixel_writer_pkg.sv
// Shared definitions for the block pixel writer: default geometry, the
// write-out FSM state type and the raster address helper.
package block_pixel_writer_pkg;

  localparam int unsigned DEF_PIX_W  = 8;
  localparam int unsigned DEF_BLK    = 8;
  localparam int unsigned DEF_IMG_W  = 32;
  localparam int unsigned DEF_IMG_H  = 32;
  localparam int unsigned DEF_ADDR_W = 10;

  localparam int unsigned BLK_PIX      = DEF_BLK * DEF_BLK;
  localparam int unsigned BLKS_PER_ROW = DEF_IMG_W / DEF_BLK;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Frame address of pixel p inside block (blk_row, blk_col). All sizes are
  // powers of two, so the address is built from shifts and masks only.
  function automatic int unsigned pix_addr(input int unsigned blk_row,
                                           input int unsigned blk_col,
                                           input int unsigned p,
                                           input int unsigned log_blk,
                                           input int unsigned log_w);
    int unsigned line;
    int unsigned x;
    line = (blk_row << log_blk) | (p >> log_blk);
    x    = (blk_col << log_blk) | (p & ((32'd1 << log_blk) - 32'd1));
    return (line << log_w) | x;
  endfunction

endpackage

// File: rtl/block_pixel_writer_buffer.sv
// block_pixel_buffer: holds one reconstructed block.
//   clk        clock
//   load       capture all pixels from pixels this cycle
//   pixels     flat block, pixel k at [k*PIX_W +: PIX_W]
//   rd_idx     pixel index to read
//   rd_data_c  combinational read of the stored pixel at rd_idx
module block_pixel_buffer #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       load,
  input  logic [DEPTH*PIX_W-1:0]     pixels,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [PIX_W-1:0]           rd_data_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];

  // Parallel load; contents are not reset since a block is always loaded
  // before it is read.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[IDX_W'(k)] <= pixels[k*PIX_W +: PIX_W];
      end
    end
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/block_pixel_writer.sv
// block_pixel_writer: captures a reconstructed block and streams it into a
// raster frame buffer, one pixel per accepted write.
//   clk, reset   clock, synchronous active-high reset
//   blk_valid    block pixels valid this cycle
//   blk_pixels   flat block, pixel k = row*BLK + col at [k*PIX_W +: PIX_W]
//   blk_ready    a new block can be captured
//   wr_en        frame-buffer write request
//   wr_addr      frame-buffer word address
//   wr_data      pixel to write
//   wr_ready     frame buffer accepts the write this cycle
//   busy         block held, write-out in progress
//   frame_done   one-cycle pulse after the last block of a frame is written
//   overrun      sticky: block offered while not ready (dropped)
module block_pixel_writer
  import block_pixel_writer_pkg::*;
#(
  parameter int unsigned PIX_W  = DEF_PIX_W,
  parameter int unsigned BLK    = DEF_BLK,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       blk_valid,
  input  logic [BLK*BLK*PIX_W-1:0]   blk_pixels,
  output logic                       blk_ready,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [PIX_W-1:0]           wr_data,
  input  logic                       wr_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int unsigned PIX_PER_BLK = BLK * BLK;
  localparam int unsigned P_W         = $clog2(PIX_PER_BLK);
  localparam int unsigned COLS        = IMG_W / BLK;
  localparam int unsigned ROWS        = IMG_H / BLK;
  localparam int unsigned NUM_BLKS    = COLS * ROWS;
  localparam int unsigned IDX_W       = $clog2(NUM_BLKS);
  localparam int unsigned LOG_BLK     = $clog2(BLK);
  localparam int unsigned LOG_W       = $clog2(IMG_W);
  localparam int unsigned LOG_COLS    = $clog2(COLS);

  state_t             state;
  logic [P_W-1:0]     p;
  logic [P_W-1:0]     p_nxt;
  logic [IDX_W-1:0]   blk_idx;
  logic [PIX_W-1:0]   buf_rd_c;
  logic               load;
  int unsigned        blk_row;
  int unsigned        blk_col;

  assign p_nxt   = p + P_W'(1);
  assign load    = (state == IDLE) && blk_valid;
  // Linear block index: column in the low bits, row above it.
  assign blk_row = 32'(blk_idx) >> LOG_COLS;
  assign blk_col = 32'(blk_idx) & (COLS - 1);

  block_pixel_buffer #(
    .PIX_W (PIX_W),
    .DEPTH (PIX_PER_BLK)
  ) u_buf (
    .clk       (clk),
    .load      (load),
    .pixels    (blk_pixels),
    .rd_idx    (p_nxt),
    .rd_data_c (buf_rd_c)
  );

  // Write-out FSM. The buffer is read one pixel ahead so the next address and
  // data are registered on the edge that completes the current write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      p          <= '0;
      blk_idx    <= '0;
      blk_ready  <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (blk_valid) begin
            state     <= WRITE;
            p         <= '0;
            blk_ready <= 1'b0;
            busy      <= 1'b1;
            wr_en     <= 1'b1;
            // Pixel 0 comes straight from the input; the buffer loads on this edge.
            wr_addr   <= ADDR_W'(pix_addr(blk_row, blk_col, 32'd0, LOG_BLK, LOG_W));
            wr_data   <= blk_pixels[PIX_W-1:0];
          end
        end
        WRITE: begin
          if (blk_valid) begin
            overrun <= 1'b1;
          end
          if (wr_ready) begin
            if (p == P_W'(PIX_PER_BLK - 1)) begin
              state     <= IDLE;
              blk_ready <= 1'b1;
              busy      <= 1'b0;
              wr_en     <= 1'b0;
              blk_idx   <= blk_idx + IDX_W'(1);
              if (blk_idx == IDX_W'(NUM_BLKS - 1)) begin
                frame_done <= 1'b1;
              end
            end else begin
              p       <= p_nxt;
              wr_addr <= ADDR_W'(pix_addr(blk_row, blk_col, 32'(p_nxt), LOG_BLK, LOG_W));
              wr_data <= buf_rd_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_pixel_writer.sv
// Directed self-checking bench for block_pixel_writer.
module tb_block_pixel_writer;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic [511:0] blk_pixels;
  logic         blk_ready;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         wr_ready;
  logic         busy;
  logic         frame_done;
  logic         overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int hits [1024];

  always #5 clk = ~clk;

  block_pixel_writer dut (
    .clk        (clk),
    .reset      (reset),
    .blk_valid  (blk_valid),
    .blk_pixels (blk_pixels),
    .blk_ready  (blk_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: pixel k = base + k; mode 1: every pixel = base
  function automatic logic [511:0] make_blk(input int base, input int mode);
    logic [511:0] v;
    for (int k = 0; k < 64; k++) begin
      v[k*8 +: 8] = (mode == 0) ? 8'(base + k) : 8'(base);
    end
    return v;
  endfunction

  // Present a block for one cycle; returns in the first write-out cycle.
  task automatic send_block(input logic [511:0] pix);
    chk("send_blk_ready", 32'(blk_ready), 32'd1);
    blk_valid  = 1'b1;
    blk_pixels = pix;
    step();
    blk_valid  = 1'b0;
  endtask

  // Follow one block's write-out, checking every presented address/data
  // against the raster model. pulse_at: cycle offset for a stray blk_valid;
  // abort_p: stop following when this pixel index is reached.
  task automatic write_out(input int bidx, input logic [511:0] pix, input bit toggle,
                           input int pulse_at, input int abort_p, output int cyc);
    int p;
    int row;
    int col;
    int exp_addr;
    logic [7:0] exp_data;
    row = bidx / 4;
    col = bidx % 4;
    p   = 0;
    cyc = 0;
    while (p < 64 && cyc < 400) begin
      if (p == abort_p) break;
      wr_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (cyc == pulse_at) begin
        blk_valid  = 1'b1;
        blk_pixels = ~pix;
      end else begin
        blk_valid  = 1'b0;
        blk_pixels = pix;
      end
      exp_addr = (row * 8 + p / 8) * 32 + col * 8 + p % 8;
      exp_data = pix[p*8 +: 8];
      chk("wo_wr_en", 32'(wr_en), 32'd1);
      chk("wo_wr_addr", 32'(wr_addr), 32'(exp_addr));
      chk("wo_wr_data", 32'(wr_data), 32'(exp_data));
      if (wr_ready) begin
        hits[exp_addr]++;
        p++;
      end
      step();
      cyc++;
    end
    blk_valid = 1'b0;
    wr_ready  = 1'b1;
    if (abort_p < 0) begin
      chk("wo_complete", 32'(p), 32'd64);
      chk("wo_ready_back", 32'(blk_ready), 32'd1);
      chk("wo_wr_en_low", 32'(wr_en), 32'd0);
      chk("wo_busy_low", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    int t0;
    int bad;

    reset      = 1'b1;
    blk_valid  = 1'b0;
    blk_pixels = '0;
    wr_ready   = 1'b1;
    step();
    step();
    chk("rst_blk_ready", 32'(blk_ready), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    step();

    // Block 0, pixel k = k: addr 0..7, 32..39, ... 224..231.
    send_block(make_blk(0, 0));
    chk("b0_busy", 32'(busy), 32'd1);
    chk("b0_first_addr", 32'(wr_addr), 32'd0);
    write_out(0, make_blk(0, 0), 1'b0, -1, -1, cyc);
    chk("b0_cycles", 32'(cyc), 32'd64);
    chk("b0_frame_done", 32'(frame_done), 32'd0);

    // Block 1, pixel k = 100 + k: starts at addr 8 data 100, ends 239 / 163.
    send_block(make_blk(100, 0));
    chk("b1_first_addr", 32'(wr_addr), 32'd8);
    chk("b1_first_data", 32'(wr_data), 32'd100);
    write_out(1, make_blk(100, 0), 1'b0, -1, -1, cyc);
    chk("b1_cycles", 32'(cyc), 32'd64);
    chk("b1_last_addr", 32'(wr_addr), 32'd239);
    chk("b1_last_data", 32'(wr_data), 32'd163);

    // Full frame of 16 back-to-back blocks, block b filled with value b.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) hits[i] = 0;
    t0 = cycle;
    for (int b = 0; b < 16; b++) begin
      send_block(make_blk(b, 1));
      write_out(b, make_blk(b, 1), 1'b0, -1, -1, cyc);
      chk("frame_done_at_block_end", 32'(frame_done), (b == 15) ? 32'd1 : 32'd0);
    end
    chk("frame_done_latency", 32'(cycle - t0), 32'd1040);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (hits[i] != 1) bad++;
    chk("frame_coverage_bad", 32'(bad), 32'd0);
    step();
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);

    // Wrapped to block 0; wr_ready toggling 1,0,1,0 doubles the write-out.
    send_block(make_blk(0, 0));
    chk("wrap_first_addr", 32'(wr_addr), 32'd0);
    write_out(0, make_blk(0, 0), 1'b1, -1, -1, cyc);
    chk("stall_writeout_cycles", 32'(cyc), 32'd127);

    // Block 1 with a stray blk_valid at N+10: dropped, overrun sticky.
    chk("ovr_before", 32'(overrun), 32'd0);
    send_block(make_blk(50, 0));
    write_out(1, make_blk(50, 0), 1'b0, 9, -1, cyc);
    chk("ovr_cycles", 32'(cyc), 32'd64);
    chk("ovr_set", 32'(overrun), 32'd1);

    // Block 2 lands at index 2 (addr 16); reset at p = 20.
    send_block(make_blk(200, 0));
    chk("b2_first_addr", 32'(wr_addr), 32'd16);
    write_out(2, make_blk(200, 0), 1'b0, -1, 20, cyc);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_blk_ready", 32'(blk_ready), 32'd1);
    chk("abort_overrun", 32'(overrun), 32'd0);
    chk("abort_busy_low", 32'(busy), 32'd0);

    send_block(make_blk(7, 0));
    chk("post_abort_addr", 32'(wr_addr), 32'd0);
    chk("post_abort_data", 32'(wr_data), 32'd7);
    write_out(0, make_blk(7, 0), 1'b0, -1, -1, cyc);
    chk("post_abort_cycles", 32'(cyc), 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
